// File: rtl/shift_reg_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register.
// Takes one LOAD/SHR/SHL/ROTR command at a time over valid/ready.
// It drives the register's mode, parallel input and serial input until the command completes.
// During shifts it feeds the register's own contents back in, so each edge moves the current value.
module shift_reg_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_sin,
    input  logic [WIDTH-1:0] q_in,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] din,
    output logic             sin,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] REM_ZERO = '0;
    localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sin_q, sin_d;
    logic             accept;

    // Ready only while idle and not being reset, so a command is never taken on a reset edge.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && !rst;
        accept    = cmd_valid && cmd_ready;
    end

    // Next-state logic: capture the command on accept, then count shifts down to completion.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        data_d  = data_q;
        sin_d   = sin_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    sin_d  = cmd_sin;
                    rem_d  = cmd_cnt;
                    if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (cmd_cnt == REM_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                rem_d = rem_q - REM_ONE;
                if (rem_q == REM_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and capture registers; reset also abandons any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            sin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            data_q  <= data_d;
            sin_q   <= sin_d;
        end
    end

    // Register controls decoded from the current state.
    // While shifting, q_in passes straight through so each edge moves the present contents.
    always_comb begin
        s    = MODE_HOLD;
        din  = '0;
        sin  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            ST_LOAD: begin
                s    = MODE_LOAD;
                din  = data_q;
                busy = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                din  = q_in;
                case (op_q)
                    OP_SHL: begin
                        s   = MODE_SHL;
                        sin = sin_q;
                    end
                    OP_ROTR: begin
                        s   = MODE_SHR;
                        sin = q_in[0];
                    end
                    OP_SHR: begin
                        s   = MODE_SHR;
                        sin = sin_q;
                    end
                    default: begin
                        s   = MODE_HOLD;
                        sin = 1'b0;
                    end
                endcase
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                s = MODE_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Self-checking bench for shift_reg_seq_ctrl.
// Includes a behavioural 4-bit universal shift register so the real shift effects can be observed.
module tb_shift_reg_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [3:0] cmd_data;
    logic       cmd_sin;
    logic [3:0] q = 4'b0000;
    logic [1:0] s;
    logic [3:0] din;
    logic       sin;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] op;
        logic [2:0] cnt;
        logic [3:0] data;
        logic       sin;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[14];

    shift_reg_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .cmd_sin   (cmd_sin),
        .q_in      (q),
        .s         (s),
        .din       (din),
        .sin       (sin),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Universal shift register driven by the controller; it is deliberately not reset.
    always @(posedge clk) begin
        case (s)
            2'b01:   q <= {sin, din[3:1]};
            2'b10:   q <= {din[2:0], sin};
            2'b11:   q <= din;
            default: q <= q;
        endcase
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Issue one command and check the cycle-by-cycle behaviour until the controller is ready again.
    task automatic applyStimulus(input vec_t v, input int idx);
        int        load_cyc = 0;
        int        shift_cyc = 0;
        int        busy_cyc = 0;
        int        done_cyc = 0;
        int        done_at = -1;
        int        ready_at = -1;
        int        bad = 0;
        bit        is_load;
        logic [1:0] exp_mode;
        int        n;
        is_load  = (v.op == 2'b00);
        exp_mode = (v.op == 2'b10) ? 2'b10 : 2'b01;
        n        = int'(v.cnt);

        @(negedge clk);
        checkOutput($sformatf("v%0d_ready_before", idx), int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_cnt   = v.cnt;
        cmd_data  = v.data;
        cmd_sin   = v.sin;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = ~v.data;
        cmd_sin   = ~v.sin;
        cmd_cnt   = 3'd7;
        cmd_op    = ~v.op;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (s == 2'b11) begin
                load_cyc++;
                if (din != v.data) bad++;
            end else if (s != 2'b00) begin
                if (s == exp_mode) shift_cyc++;
                else bad++;
                if (din != q) bad++;
                if (v.op == 2'b11) begin
                    if (sin != q[0]) bad++;
                end else if (sin != v.sin) begin
                    bad++;
                end
            end
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc++;
                if (done_at < 0) done_at = k;
            end
            if (done && cmd_ready) bad++;
            if (cmd_ready) begin
                ready_at = k;
                break;
            end
        end
        checkOutput($sformatf("v%0d_q", idx), int'(q), int'(v.exp_q));
        checkOutput($sformatf("v%0d_load_cycles", idx), load_cyc, is_load ? 1 : 0);
        checkOutput($sformatf("v%0d_shift_cycles", idx), shift_cyc, is_load ? 0 : n);
        checkOutput($sformatf("v%0d_busy_cycles", idx), busy_cyc, is_load ? 1 : n);
        checkOutput($sformatf("v%0d_done_at", idx), done_at, is_load ? 2 : n + 1);
        checkOutput($sformatf("v%0d_done_width", idx), done_cyc, 1);
        checkOutput($sformatf("v%0d_ready_at", idx), ready_at, is_load ? 3 : n + 2);
        checkOutput($sformatf("v%0d_bad_outputs", idx), bad, 0);
    endtask

    initial begin
        int  accepts;
        bit  seen_done;
        int  done_seen;

        // op, cnt, data, sin, expected q after the command
        vecs[0]  = '{2'b00, 3'd0, 4'b1011, 1'b0, 4'b1011};
        vecs[1]  = '{2'b01, 3'd2, 4'b0000, 1'b1, 4'b1110};
        vecs[2]  = '{2'b00, 3'd5, 4'b0111, 1'b1, 4'b0111};
        vecs[3]  = '{2'b10, 3'd3, 4'b1111, 1'b0, 4'b1000};
        vecs[4]  = '{2'b11, 3'd1, 4'b0000, 1'b1, 4'b0100};
        vecs[5]  = '{2'b11, 3'd4, 4'b0000, 1'b0, 4'b0100};
        vecs[6]  = '{2'b01, 3'd0, 4'b1111, 1'b1, 4'b0100};
        vecs[7]  = '{2'b10, 3'd7, 4'b0000, 1'b1, 4'b1111};
        vecs[8]  = '{2'b01, 3'd5, 4'b1111, 1'b0, 4'b0000};
        vecs[9]  = '{2'b00, 3'd0, 4'b1001, 1'b0, 4'b1001};
        vecs[10] = '{2'b11, 3'd3, 4'b0000, 1'b0, 4'b0011};
        vecs[11] = '{2'b10, 3'd1, 4'b0000, 1'b1, 4'b0111};
        vecs[12] = '{2'b11, 3'd7, 4'b0000, 1'b0, 4'b1110};
        vecs[13] = '{2'b11, 3'd0, 4'b0000, 1'b1, 4'b1110};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = 3'd0;
        cmd_data  = 4'b0000;
        cmd_sin   = 1'b0;

        // Reset held for two cycles.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rst%0d_s", c), int'(s), 0);
            checkOutput($sformatf("rst%0d_busy", c), int'(busy), 0);
            checkOutput($sformatf("rst%0d_done", c), int'(done), 0);
            checkOutput($sformatf("rst%0d_ready", c), int'(cmd_ready), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_ready", int'(cmd_ready), 1);
        checkOutput("after_rst_din", int'(din), 0);
        checkOutput("after_rst_sin", int'(sin), 0);

        // Table-driven commands, each chaining on the previous register contents.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        // Valid held high throughout a command must be accepted only once.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = 3'd2;
        cmd_sin   = 1'b0;
        accepts   = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (cmd_valid && cmd_ready) accepts++;
            if (done) begin
                seen_done = 1'b1;
                cmd_valid = 1'b0;
                break;
            end
        end
        cmd_valid = 1'b0;
        checkOutput("hold_accepts", accepts, 1);
        checkOutput("hold_done_seen", int'(seen_done), 1);
        checkOutput("hold_q", int'(q), 4'b0011);
        @(negedge clk);
        checkOutput("hold_ready_back", int'(cmd_ready), 1);

        // Reset in the middle of a five-step right shift.
        applyStimulus('{2'b00, 3'd0, 4'b1010, 1'b0, 4'b1010}, 99);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = 3'd5;
        cmd_sin   = 1'b0;
        done_seen = 0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("midrst_k1_s", int'(s), 1);
        if (done) done_seen++;
        @(negedge clk);
        checkOutput("midrst_k2_s", int'(s), 1);
        if (done) done_seen++;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_k3_s", int'(s), 0);
        checkOutput("midrst_k3_busy", int'(busy), 0);
        checkOutput("midrst_k3_ready", int'(cmd_ready), 0);
        if (done) done_seen++;
        rst = 1'b0;
        @(negedge clk);
        if (done) done_seen++;
        checkOutput("midrst_ready_after", int'(cmd_ready), 1);
        checkOutput("midrst_q", int'(q), 4'b0010);
        @(negedge clk);
        if (done) done_seen++;
        checkOutput("midrst_no_done", done_seen, 0);
        checkOutput("midrst_q_stable", int'(q), 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
